dma_engine: RTL and testbench

Parametrised multi-channel DMA controller for the CPU memory bus. It takes over the bus while the execution FSM is frozen via `halt`, and generalises the fixed single-channel OAM DMA stall into CH independent channels. Each channel has its own programmable length, source base and destination mode. It sits beside the CPU execution FSM and interrupt handler, and muxes onto the shared memory bus while `halt` is high.

---
 rtl/dma_engine.sv | 202 ++++++++++++++++++++
 tb/tb_dma_engine.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_engine.sv
// Multi-channel byte-copy DMA: halts the CPU, owns the memory bus and copies
// len bytes per channel from src_base to a fixed or incrementing destination.
module dma_engine #(
   parameter int CH         = 2,
   parameter int LEN_W      = 9,
   parameter int HALT_DELAY = 5,
   parameter int READ_LAT   = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CH-1:0]       start,
   input  logic                abort,
   input  logic [CH*16-1:0]    src_base,
   input  logic [CH*16-1:0]    dst_addr,
   input  logic [CH-1:0]       dst_inc,
   input  logic [CH*LEN_W-1:0] len,
   output logic [15:0]         mem_addr,
   output logic [7:0]          mem_data_out,
   input  logic [7:0]          mem_data_in,
   output logic                mem_read_en,
   output logic                mem_write_en,
   output logic                halt,
   output logic [CH-1:0]       busy,
   output logic [CH-1:0]       done
);
   // state     | meaning
   // IDLE      | bus released or between channels; grants lowest pending channel
   // HALT_WAIT | halt is high, CPU parking for HALT_DELAY cycles
   // RD        | read strobe at src_base + idx
   // RWAIT     | read latency; mem_data_in captured on the last edge
   // WR        | write strobe at dst; advances idx and finishes the channel at len
   typedef enum logic [2:0] {
      S_IDLE,
      S_HALT_WAIT,
      S_RD,
      S_RWAIT,
      S_WR
   } state_t;

   localparam int CH_W    = (CH > 1) ? $clog2(CH) : 1;
   localparam int CNT_MAX = (HALT_DELAY > READ_LAT) ? HALT_DELAY : READ_LAT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   state_t             state_q, state_d;
   logic [CH-1:0]      pending_q, pending_d;
   logic [CH-1:0]      active_q, active_d;
   logic [CH-1:0]      done_q, done_d;
   logic               halt_q, halt_d;
   logic [CH_W-1:0]    ch_q, ch_d;
   logic [LEN_W-1:0]   idx_q, idx_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [15:0]        src_q, src_d;
   logic [15:0]        dst_q, dst_d;
   logic               inc_q, inc_d;
   logic [7:0]         data_q, data_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [15:0]        addr_q;

   logic [CH_W-1:0]    gnt_ch;
   logic [LEN_W-1:0]   gnt_len;
   logic [LEN_W-1:0]   idx_inc;

   always_comb begin
      gnt_ch = '0;
      for (int i = CH - 1; i >= 0; i--) begin
         if (pending_q[i]) gnt_ch = CH_W'(i);
      end
   end

   assign gnt_len = len[gnt_ch*LEN_W +: LEN_W];
   assign idx_inc = idx_q + 1'b1;

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q | (start & ~(pending_q | active_q));
      active_d  = active_q;
      done_d    = '0;
      halt_d    = halt_q;
      ch_d      = ch_q;
      idx_d     = idx_q;
      len_d     = len_q;
      src_d     = src_q;
      dst_d     = dst_q;
      inc_d     = inc_q;
      data_d    = data_q;
      cnt_d     = cnt_q;

      case (state_q)
         S_IDLE: begin
            if (|pending_q) begin
               pending_d[gnt_ch] = 1'b0;
               ch_d  = gnt_ch;
               idx_d = '0;
               len_d = gnt_len;
               src_d = src_base[gnt_ch*16 +: 16];
               dst_d = dst_addr[gnt_ch*16 +: 16];
               inc_d = dst_inc[gnt_ch];
               if (gnt_len == '0) begin
                  // Empty transfer: complete at once, never raise halt for it.
                  done_d[gnt_ch] = 1'b1;
                  halt_d = halt_q & (|pending_d);
               end else begin
                  active_d[gnt_ch] = 1'b1;
                  halt_d = 1'b1;
                  if (halt_q) begin
                     state_d = S_RD;
                  end else begin
                     state_d = S_HALT_WAIT;
                     cnt_d   = CNT_W'(HALT_DELAY - 1);
                  end
               end
            end
         end
         S_HALT_WAIT: begin
            if (cnt_q == '0) state_d = S_RD;
            else             cnt_d   = cnt_q - 1'b1;
         end
         S_RD: begin
            state_d = S_RWAIT;
            cnt_d   = CNT_W'(READ_LAT - 1);
         end
         S_RWAIT: begin
            if (cnt_q == '0) begin
               data_d  = mem_data_in;
               state_d = S_WR;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_WR: begin
            idx_d = idx_inc;
            if (inc_q) dst_d = dst_q + 16'd1;
            if (idx_inc == len_q) begin
               done_d[ch_q] = 1'b1;
               active_d     = '0;
               halt_d       = |pending_d;
               state_d      = S_IDLE;
            end else begin
               state_d = S_RD;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (abort) begin
         state_d   = S_IDLE;
         pending_d = '0;
         active_d  = '0;
         done_d    = '0;
         halt_d    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         pending_q <= '0;
         active_q  <= '0;
         done_q    <= '0;
         halt_q    <= 1'b0;
         ch_q      <= '0;
         idx_q     <= '0;
         len_q     <= '0;
         src_q     <= '0;
         dst_q     <= '0;
         inc_q     <= 1'b0;
         data_q    <= '0;
         cnt_q     <= '0;
         addr_q    <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         active_q  <= active_d;
         done_q    <= done_d;
         halt_q    <= halt_d;
         ch_q      <= ch_d;
         idx_q     <= idx_d;
         len_q     <= len_d;
         src_q     <= src_d;
         dst_q     <= dst_d;
         inc_q     <= inc_d;
         data_q    <= data_d;
         cnt_q     <= cnt_d;
         addr_q    <= mem_addr;
      end
   end

   // Address holds its last bus value outside RD/WR.
   always_comb begin
      mem_addr = addr_q;
      if (state_q == S_RD)      mem_addr = src_q + 16'(idx_q);
      else if (state_q == S_WR) mem_addr = dst_q;
   end

   assign mem_read_en  = (state_q == S_RD) && !abort;
   assign mem_write_en = (state_q == S_WR) && !abort;
   assign mem_data_out = data_q;
   assign halt         = halt_q;
   assign busy         = pending_q | active_q;
   assign done         = done_q;

endmodule

// File: tb/tb_dma_engine.sv
// Self-checking bench for dma_engine: hand-derived vector table, event-level
// reference model for random transfers, and abort / reset / repeat-start sequences.
module tb_dma_engine;
   localparam int CH         = 2;
   localparam int LEN_W      = 9;
   localparam int HALT_DELAY = 5;
   localparam int READ_LAT   = 2;
   localparam int BYTE_CYC   = READ_LAT + 2;

   localparam int K_RD   = 0;
   localparam int K_WR   = 1;
   localparam int K_DONE = 2;
   localparam int K_HALT = 3;

   typedef struct {
      int cyc;
      int kind;
      int addr;
      int data;
   } ev_t;

   typedef struct {
      logic [1:0]  mask;
      int          len0;
      int          len1;
      logic [15:0] src0;
      logic [15:0] src1;
      logic [15:0] dst0;
      logic [15:0] dst1;
      logic        inc0;
      logic        inc1;
      int          e_done0;
      int          e_done1;
      int          e_rise;
      int          e_rd;
   } vec_t;

   logic                clk = 1'b0;
   logic                rst;
   logic [CH-1:0]       start;
   logic                abort;
   logic [CH*16-1:0]    src_base;
   logic [CH*16-1:0]    dst_addr;
   logic [CH-1:0]       dst_inc;
   logic [CH*LEN_W-1:0] len;
   logic [15:0]         mem_addr;
   logic [7:0]          mem_data_out;
   logic [7:0]          mem_data_in;
   logic                mem_read_en;
   logic                mem_write_en;
   logic                halt;
   logic [CH-1:0]       busy;
   logic [CH-1:0]       done;

   logic [15:0] c_src [2];
   logic [15:0] c_dst [2];
   logic        c_inc [2];
   int          c_len [2];
   logic [7:0]  mem_key;

   int cyc = 0;
   int checks;
   int errors;
   ev_t act_q[$];
   ev_t exp_q[$];
   logic halt_prev = 1'b0;
   logic [16:0] rd_pipe [READ_LAT];

   assign src_base = {c_src[1], c_src[0]};
   assign dst_addr = {c_dst[1], c_dst[0]};
   assign dst_inc  = {c_inc[1], c_inc[0]};
   assign len      = {9'(c_len[1]), 9'(c_len[0])};

   dma_engine #(
      .CH(CH), .LEN_W(LEN_W), .HALT_DELAY(HALT_DELAY), .READ_LAT(READ_LAT)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .src_base(src_base), .dst_addr(dst_addr), .dst_inc(dst_inc), .len(len),
      .mem_addr(mem_addr), .mem_data_out(mem_data_out), .mem_data_in(mem_data_in),
      .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
      .halt(halt), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Memory returns addr[7:0]^key only in the exact cycle the read data is due.
   always @(posedge clk) begin
      rd_pipe[0] <= {mem_read_en, mem_addr};
      for (int k = 1; k < READ_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
   end
   assign mem_data_in = rd_pipe[READ_LAT-1][16] ? (rd_pipe[READ_LAT-1][7:0] ^ mem_key) : 8'hEE;

   always @(negedge clk) begin
      if (mem_read_en)  act_q.push_back('{cyc, K_RD, int'(mem_addr), 0});
      if (mem_write_en) act_q.push_back('{cyc, K_WR, int'(mem_addr), int'(mem_data_out)});
      for (int i = 0; i < CH; i++)
         if (done[i]) act_q.push_back('{cyc, K_DONE, i, 0});
      if (halt !== halt_prev) act_q.push_back('{cyc, K_HALT, 0, int'(halt)});
      halt_prev <= halt;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int target);
      while (cyc < target) step();
   endtask

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   function automatic int count_kind(input int kind);
      int n = 0;
      foreach (act_q[i]) if (act_q[i].kind == kind) n++;
      return n;
   endfunction

   // key: channel for DONE, level for HALT, ignored for RD (-1)
   function automatic int find_first(input int kind, input int key, input int s0);
      foreach (act_q[i]) begin
         if (act_q[i].kind == kind &&
             (key < 0 || (kind == K_DONE && act_q[i].addr == key) ||
              (kind == K_HALT && act_q[i].data == key)))
            return act_q[i].cyc - s0;
      end
      return -1;
   endfunction

   task automatic push_exp(input int c, input int k, input int a, input int d);
      exp_q.push_back('{c, k, a, d});
   endtask

   // Reference: channels of a simultaneous request mask are served in index
   // order; halt is raised HALT_DELAY cycles ahead of the first read, each byte
   // costs BYTE_CYC cycles, and done lands one cycle after the last write.
   task automatic build_exp(input logic [1:0] mask, input int s0);
      int  t;
      int  first_rd;
      int  d;
      bit  h;
      bit  rem;
      exp_q.delete();
      t = s0 + 1;
      h = 1'b0;
      for (int ch = 0; ch < CH; ch++) begin
         if (mask[ch]) begin
            rem = (ch == 0) && mask[1];
            if (c_len[ch] == 0) begin
               push_exp(t + 1, K_DONE, ch, 0);
               if (h && !rem) push_exp(t + 1, K_HALT, 0, 0);
               h = h && rem;
               t = t + 1;
            end else begin
               if (!h) begin
                  push_exp(t + 1, K_HALT, 0, 1);
                  first_rd = t + 1 + HALT_DELAY;
               end else begin
                  first_rd = t + 1;
               end
               for (int k = 0; k < c_len[ch]; k++) begin
                  int sa;
                  int da;
                  sa = (int'(c_src[ch]) + k) % 65536;
                  da = c_inc[ch] ? (int'(c_dst[ch]) + k) % 65536 : int'(c_dst[ch]);
                  push_exp(first_rd + k*BYTE_CYC, K_RD, sa, 0);
                  push_exp(first_rd + k*BYTE_CYC + READ_LAT + 1, K_WR, da,
                           int'(8'(sa) ^ mem_key));
               end
               d = first_rd + c_len[ch]*BYTE_CYC;
               push_exp(d, K_DONE, ch, 0);
               if (!rem) push_exp(d, K_HALT, 0, 0);
               h = rem;
               t = d;
            end
         end
      end
   endtask

   task automatic compare_events(input string tag);
      int n;
      chk({tag, "_event_count"}, act_q.size(), exp_q.size());
      n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         checks++;
         if (act_q[i].cyc != exp_q[i].cyc || act_q[i].kind != exp_q[i].kind ||
             act_q[i].addr != exp_q[i].addr || act_q[i].data != exp_q[i].data) begin
            errors++;
            $display("FAIL %s_ev[%0d] actual cyc=%0d kind=%0d addr=%h data=%h required cyc=%0d kind=%0d addr=%h data=%h",
                     tag, i, act_q[i].cyc, act_q[i].kind, act_q[i].addr, act_q[i].data,
                     exp_q[i].cyc, exp_q[i].kind, exp_q[i].addr, exp_q[i].data);
         end
      end
   endtask

   task automatic run_case(input string tag, input logic [1:0] mask, output int s0);
      int last;
      act_q.delete();
      s0 = cyc;
      start = mask;
      step();
      start = '0;
      build_exp(mask, s0);
      last = (exp_q.size() > 0) ? exp_q[exp_q.size()-1].cyc : s0;
      wait_until(last + 4);
      compare_events(tag);
      chk({tag, "_busy_end"}, busy, 0);
   endtask

   task automatic set_cfg(input int l0, input int l1, input logic [15:0] s0v, input logic [15:0] s1v,
                          input logic [15:0] d0, input logic [15:0] d1, input logic i0, input logic i1);
      c_len[0] = l0; c_len[1] = l1;
      c_src[0] = s0v; c_src[1] = s1v;
      c_dst[0] = d0; c_dst[1] = d1;
      c_inc[0] = i0; c_inc[1] = i1;
   endtask

   vec_t vecs [5];

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int s0;
      checks  = 0;
      errors  = 0;
      rst     = 1'b0;
      start   = '0;
      abort   = 1'b0;
      mem_key = 8'h00;
      set_cfg(0, 0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);

      vecs[0] = '{2'b01, 256, 0, 16'h0200, 16'h0000, 16'h2004, 16'h0000, 1'b0, 1'b0, 1031, -1, 2, 7};
      vecs[1] = '{2'b10, 0, 4, 16'h0000, 16'hFFFE, 16'h0000, 16'h0300, 1'b0, 1'b1, -1, 23, 2, 7};
      vecs[2] = '{2'b11, 3, 3, 16'h0010, 16'h0020, 16'h0100, 16'h0200, 1'b1, 1'b1, 19, 32, 2, 7};
      vecs[3] = '{2'b01, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 2, -1, -1, -1};
      vecs[4] = '{2'b11, 0, 2, 16'h0000, 16'hABCD, 16'h0000, 16'h2004, 1'b0, 1'b0, 2, 16, 3, 8};

      step();
      step();
      chk("reset_outputs", {mem_addr, mem_data_out, mem_read_en, mem_write_en, halt, busy, done}, 0);
      rst = 1'b1;
      step();
      step();

      for (int v = 0; v < 5; v++) begin
         set_cfg(vecs[v].len0, vecs[v].len1, vecs[v].src0, vecs[v].src1,
                 vecs[v].dst0, vecs[v].dst1, vecs[v].inc0, vecs[v].inc1);
         mem_key = 8'h00;
         run_case($sformatf("vec%0d", v), vecs[v].mask, s0);
         chk($sformatf("vec%0d_done0_cyc", v), find_first(K_DONE, 0, s0), vecs[v].e_done0);
         chk($sformatf("vec%0d_done1_cyc", v), find_first(K_DONE, 1, s0), vecs[v].e_done1);
         chk($sformatf("vec%0d_halt_rise", v), find_first(K_HALT, 1, s0), vecs[v].e_rise);
         chk($sformatf("vec%0d_first_rd", v), find_first(K_RD, -1, s0), vecs[v].e_rd);
      end

      for (int r = 0; r < 8; r++) begin
         logic [1:0] m;
         m = 2'($urandom_range(1, 3));
         for (int c = 0; c < CH; c++) begin
            c_len[c] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 10));
            c_src[c] = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'hFFF8 + 16'($urandom_range(0, 7));
            c_dst[c] = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'hFFFD;
            c_inc[c] = 1'($urandom_range(0, 1));
         end
         mem_key = 8'($urandom);
         run_case($sformatf("rnd%0d", r), m, s0);
      end
      mem_key = 8'h00;

      // Abort in RWAIT of byte 10 with ch1 queued behind ch0.
      set_cfg(256, 5, 16'h0400, 16'h0600, 16'h5000, 16'h7000, 1'b1, 1'b1);
      act_q.delete();
      s0 = cyc;
      start = 2'b01;
      step();
      start = '0;
      wait_until(s0 + 3);
      start = 2'b10;
      step();
      start = '0;
      chk("abort_busy_before", busy, 2'b11);
      wait_until(s0 + 7 + 10*BYTE_CYC + 1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abort_busy_after", busy, 0);
      chk("abort_halt_after", halt, 0);
      wait_until(s0 + 120);
      chk("abort_rd_count", count_kind(K_RD), 11);
      chk("abort_wr_count", count_kind(K_WR), 10);
      chk("abort_done_count", count_kind(K_DONE), 0);
      chk("abort_halt_fall", act_q[act_q.size()-1].cyc - s0, 7 + 10*BYTE_CYC + 2);

      // Abort landing on a WR cycle must suppress that write.
      set_cfg(8, 0, 16'h0100, 16'h0, 16'h0900, 16'h0, 1'b1, 1'b0);
      act_q.delete();
      s0 = cyc;
      start = 2'b01;
      step();
      start = '0;
      wait_until(s0 + 7 + READ_LAT + 1);
      abort = 1'b1;
      #1;
      chk("abort_wr_strobe", mem_write_en, 0);
      step();
      abort = 1'b0;
      wait_until(s0 + 30);
      chk("abortwr_wr_count", count_kind(K_WR), 0);
      chk("abortwr_done_count", count_kind(K_DONE), 0);

      // start together with abort in IDLE is discarded.
      act_q.delete();
      start = 2'b01;
      abort = 1'b1;
      step();
      start = '0;
      abort = 1'b0;
      chk("abort_start_busy", busy, 0);
      wait_until(cyc + 12);
      chk("abort_start_events", act_q.size(), 0);

      // Repeated start[0] while ch0 is active is ignored.
      set_cfg(5, 0, 16'h1000, 16'h0, 16'h2004, 16'h0, 1'b0, 1'b0);
      act_q.delete();
      s0 = cyc;
      start = 2'b01;
      step();
      start = '0;
      wait_until(s0 + 10);
      start = 2'b01;
      step();
      start = '0;
      build_exp(2'b01, s0);
      wait_until(exp_q[exp_q.size()-1].cyc + 6);
      compare_events("repeat");
      chk("repeat_done_count", count_kind(K_DONE), 1);

      // Reset mid-transfer clears outputs asynchronously and drops the transfer.
      set_cfg(20, 0, 16'h3000, 16'h0, 16'h4000, 16'h0, 1'b1, 1'b0);
      act_q.delete();
      s0 = cyc;
      start = 2'b01;
      step();
      start = '0;
      wait_until(s0 + 7 + BYTE_CYC);
      chk("rst_rd_active", mem_read_en, 1);
      #2;
      rst = 1'b0;
      #1;
      chk("rst_async_outputs", {mem_addr, mem_data_out, mem_read_en, mem_write_en, halt, busy, done}, 0);
      step();
      step();
      rst = 1'b1;
      wait_until(cyc + 40);
      chk("rst_done_count", count_kind(K_DONE), 0);
      chk("rst_wr_count", count_kind(K_WR), 1);
      chk("rst_busy_after", busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
